// File: rtl/sd_cmd_arbiter_pkg.sv
// Shared widths and status bit positions for the SD command arbiter slice.
// Mirrors the values historically pulled from sd_defines.h.
package sd_cmd_arbiter_pkg;

    localparam int unsigned CMD_REG_SIZE  = 14;
    localparam int unsigned INT_CMD_SIZE  = 5;
    localparam int unsigned CMD_TIMEOUT_W = 16;

    localparam int unsigned INT_CMD_EI  = 1;
    localparam int unsigned INT_CMD_CTE = 2;

    typedef logic [INT_CMD_SIZE-1:0] cmd_status_t;

    // Status reported when the watchdog aborts a command: error + timeout.
    function automatic cmd_status_t timeout_status();
        cmd_status_t s;
        s = '0;
        s[INT_CMD_EI]  = 1'b1;
        s[INT_CMD_CTE] = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/sd_cmd_arbiter_if.sv
// Link between the command arbiter and the SD command master.
// master = arbiter side, slave = command master side.
interface sd_cmd_arbiter_if;
    import sd_cmd_arbiter_pkg::*;

    logic                    cmd_start;
    logic [31:0]             cmd_arg;
    logic [CMD_REG_SIZE-1:0] cmd_setting;
    logic                    cmd_abort;
    logic                    cmd_done;
    logic [INT_CMD_SIZE-1:0] cmd_status;

    modport master (
        output cmd_start, cmd_arg, cmd_setting, cmd_abort,
        input  cmd_done, cmd_status
    );

    modport slave (
        input  cmd_start, cmd_arg, cmd_setting, cmd_abort,
        output cmd_done, cmd_status
    );

endinterface

// File: rtl/sd_cmd_watchdog.sv
// Down-counting command watchdog: loaded at issue, counts while enabled,
// flags expiry on the cycle the count would reach zero.
module sd_cmd_watchdog
    import sd_cmd_arbiter_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_i,
    input  logic [CMD_TIMEOUT_W-1:0] load_val_i,
    input  logic                     en_i,
    output logic                     expired_o
);

    logic [CMD_TIMEOUT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CMD_TIMEOUT_W'(1);
        end
    end

    assign expired_o = en_i && (cnt_q == CMD_TIMEOUT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sd_cmd_arbiter.sv
// Two-requester arbiter in front of the SD command master: grants, issues,
// waits for completion (with optional watchdog) and reports status.
module sd_cmd_arbiter
    import sd_cmd_arbiter_pkg::*;
#(
    parameter int unsigned RR_EN = 1
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n_i,
    input  logic                     req0_i,
    input  logic                     req1_i,
    input  logic [31:0]              req0_arg_i,
    input  logic [31:0]              req1_arg_i,
    input  logic [CMD_REG_SIZE-1:0]  req0_cmd_i,
    input  logic [CMD_REG_SIZE-1:0]  req1_cmd_i,
    output logic                     gnt0_o,
    output logic                     gnt1_o,
    output logic                     done0_o,
    output logic                     done1_o,
    output logic [INT_CMD_SIZE-1:0]  status_o,
    input  logic [CMD_TIMEOUT_W-1:0] cmd_timeout_i,
    input  logic                     soft_rst_i,
    output logic                     cmd_start_o,
    output logic [31:0]              cmd_arg_o,
    output logic [CMD_REG_SIZE-1:0]  cmd_setting_o,
    input  logic                     cmd_done_i,
    input  logic [INT_CMD_SIZE-1:0]  cmd_status_i,
    output logic                     cmd_abort_o,
    output logic                     busy_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_e;

    state_e                  state_q, state_d;
    logic                    gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                    done0_q, done0_d, done1_q, done1_d;
    logic                    start_q, start_d, abort_q, abort_d;
    logic                    owner_q, owner_d, prio_q, prio_d;
    logic [INT_CMD_SIZE-1:0] status_q, status_d;
    logic [31:0]             arg_q, arg_d;
    logic [CMD_REG_SIZE-1:0] setting_q, setting_d;
    logic                    pick1, wd_load, wd_en, wd_expired;

    // prio_q names the requester favoured on a tie (0 after reset).
    assign pick1   = req1_i && (!req0_i || ((RR_EN != 0) && prio_q));
    assign wd_load = (state_q == ST_ISSUE);
    assign wd_en   = (state_q == ST_WAIT) && (cmd_timeout_i != '0);

    sd_cmd_watchdog u_watchdog (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_n_i),
        .load_i     (wd_load),
        .load_val_i (cmd_timeout_i),
        .en_i       (wd_en),
        .expired_o  (wd_expired)
    );

    always_comb begin
        state_d   = state_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        start_d   = 1'b0;
        abort_d   = 1'b0;
        owner_d   = owner_q;
        prio_d    = prio_q;
        status_d  = status_q;
        arg_d     = arg_q;
        setting_d = setting_q;
        if (soft_rst_i) begin
            state_d = ST_IDLE;
            abort_d = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req0_i || req1_i) begin
                        state_d   = ST_ISSUE;
                        owner_d   = pick1;
                        gnt0_d    = !pick1;
                        gnt1_d    = pick1;
                        arg_d     = pick1 ? req1_arg_i : req0_arg_i;
                        setting_d = pick1 ? req1_cmd_i : req0_cmd_i;
                    end
                end
                ST_ISSUE: begin
                    state_d = ST_WAIT;
                    start_d = 1'b1;
                end
                ST_WAIT: begin
                    // Completion outranks a simultaneous watchdog expiry.
                    if (cmd_done_i) begin
                        state_d  = ST_DONE;
                        status_d = cmd_status_i;
                        done0_d  = !owner_q;
                        done1_d  = owner_q;
                    end else if (wd_expired) begin
                        state_d  = ST_DONE;
                        abort_d  = 1'b1;
                        status_d = timeout_status();
                        done0_d  = !owner_q;
                        done1_d  = owner_q;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    prio_d  = !owner_q;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= ST_IDLE;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
            owner_q   <= 1'b0;
            prio_q    <= 1'b0;
            status_q  <= '0;
            arg_q     <= '0;
            setting_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            start_q   <= start_d;
            abort_q   <= abort_d;
            owner_q   <= owner_d;
            prio_q    <= prio_d;
            status_q  <= status_d;
            arg_q     <= arg_d;
            setting_q <= setting_d;
        end
    end

    assign gnt0_o        = gnt0_q;
    assign gnt1_o        = gnt1_q;
    assign done0_o       = done0_q;
    assign done1_o       = done1_q;
    assign status_o      = status_q;
    assign cmd_start_o   = start_q;
    assign cmd_abort_o   = abort_q;
    assign cmd_arg_o     = arg_q;
    assign cmd_setting_o = setting_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule
